// File: rtl/bridge_pkg.sv
// bridge_pkg: FSM encoding, error read data and default SoC decode
// windows shared by periph_bridge_n and its address decoder.
package bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [31:0] BRIDGE_ERR_RDATA = 32'hDEADBFEE;

    localparam logic [31:0] DRAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DRAM_MASK  = 32'hF000_0000;
    localparam logic [31:0] LED_BASE   = 32'h8000_0000;
    localparam logic [31:0] LED_MASK   = 32'hFFFF_FF00;
    localparam logic [31:0] SW_BASE    = 32'h8000_0100;
    localparam logic [31:0] SW_MASK    = 32'hFFFF_FF00;
    localparam logic [31:0] DIG_BASE   = 32'h8000_0200;
    localparam logic [31:0] DIG_MASK   = 32'hFFFF_FF00;
    localparam logic [31:0] TIMER_BASE = 32'h8000_0300;
    localparam logic [31:0] TIMER_MASK = 32'hFFFF_FF00;

    localparam int SOC_N_SLV = 5;

    localparam logic [SOC_N_SLV*32-1:0] SOC_BASE =
        {TIMER_BASE, DIG_BASE, SW_BASE, LED_BASE, DRAM_BASE};
    localparam logic [SOC_N_SLV*32-1:0] SOC_MASK =
        {TIMER_MASK, DIG_MASK, SW_MASK, LED_MASK, DRAM_MASK};

endpackage

// File: rtl/bridge_addr_decoder.sv
// bridge_addr_decoder: combinational base/mask window match with
// lowest-index priority; miss when no window matches.
module bridge_addr_decoder
    import bridge_pkg::*;
#(
    parameter int N_SLV = 5,
    parameter int AW = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = '0
) (
    input  logic [AW-1:0]    i_addr,
    output logic [N_SLV-1:0] o_hit,
    output logic             o_miss
);

    // First matching window claims the address.
    always_comb begin
        o_hit  = '0;
        o_miss = 1'b1;
        for (int i = 0; i < N_SLV; i++) begin
            if (o_miss &&
                ((i_addr & SLV_MASK[i*AW +: AW]) ==
                 (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))) begin
                o_hit[i] = 1'b1;
                o_miss   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/periph_bridge_n.sv
// periph_bridge_n: registered CPU-to-peripheral bridge with wait states
// and timeout. Optional error log registers: BRIDGE_ERRLOG_EN.
module periph_bridge_n
    import bridge_pkg::*;
#(
    parameter int N_SLV = 5,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = '0,
    parameter int TIMEOUT = 15,
    parameter logic [DW-1:0] ERR_RDATA = DW'(BRIDGE_ERR_RDATA)
`ifdef BRIDGE_ERRLOG_EN
    ,
    parameter logic [AW-1:0] ERRLOG_ADDR = AW'(32'hFFFF_F100)
`endif
) (
    input  logic                clk_from_cpu,
    input  logic                rst_from_cpu,
    input  logic                req_from_cpu,
    input  logic                we_from_cpu,
    input  logic [DW/8-1:0]     wstrb_from_cpu,
    input  logic [AW-1:0]       addr_from_cpu,
    input  logic [DW-1:0]       wdata_from_cpu,
    output logic [DW-1:0]       rdata_to_cpu,
    output logic                ack_to_cpu,
    output logic                err_to_cpu,
    output logic [N_SLV-1:0]    sel_to_slv,
    output logic                we_to_slv,
    output logic [DW/8-1:0]     wstrb_to_slv,
    output logic [AW-1:0]       addr_to_slv,
    output logic [DW-1:0]       wdata_to_slv,
    input  logic [N_SLV*DW-1:0] rdata_from_slv,
    input  logic [N_SLV-1:0]    ready_from_slv
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_SLV-1:0] r_sel;
    logic [N_SLV-1:0] w_hit;
    logic             w_miss;
    logic             r_we;
    logic [DW/8-1:0]  r_wstrb;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [DW-1:0]    r_rdata;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic             w_accept;
    logic             w_rdy;
    logic [DW-1:0]    w_slv_rdata;
    logic             w_int_hit;
    logic [DW-1:0]    w_int_rdata;

    bridge_addr_decoder #(
        .N_SLV    (N_SLV),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .i_addr (addr_from_cpu),
        .o_hit  (w_hit),
        .o_miss (w_miss)
    );

    assign w_accept  = (r_state == S_IDLE) && req_from_cpu;
    assign w_cnt_nxt = r_cnt + 8'd1;
    // An access with no slot selected is served internally: always ready.
    assign w_rdy = ~(|r_sel) | (|(ready_from_slv & r_sel));

    assign wstrb_to_slv = r_wstrb;
    assign addr_to_slv  = r_addr;
    assign wdata_to_slv = r_wdata;

    // Read data of the selected slot.
    always_comb begin
        w_slv_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (r_sel[i]) begin
                w_slv_rdata = w_slv_rdata | rdata_from_slv[i*DW +: DW];
            end
        end
    end

`ifdef BRIDGE_ERRLOG_EN
    logic [AW-1:0] r_err_addr;
    logic [7:0]    r_err_cnt;
    logic          w_log_cnt;
    logic          w_log_addr;
    logic          w_log_clr;

    assign w_log_cnt  = addr_from_cpu == ERRLOG_ADDR;
    assign w_log_addr = addr_from_cpu == (ERRLOG_ADDR + AW'(4));
    assign w_log_clr  = w_accept && we_from_cpu && w_log_cnt;
    assign w_int_hit  = we_from_cpu ? w_log_cnt : (w_log_cnt | w_log_addr);

    // Error log read data presented at accept time.
    always_comb begin
        w_int_rdata = '0;
        if (!we_from_cpu && w_log_cnt) begin
            w_int_rdata[DW-1 -: 8] = r_err_cnt;
        end else if (!we_from_cpu && w_log_addr) begin
            w_int_rdata = DW'(r_err_addr);
        end
    end

    // Record faulting address and count errors, saturating at 255.
    always_ff @(posedge clk_from_cpu or posedge rst_from_cpu) begin
        if (rst_from_cpu) begin
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else if (w_log_clr) begin
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else if (r_state == S_ERR) begin
            r_err_addr <= r_addr;
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end
`else
    assign w_int_hit   = 1'b0;
    assign w_int_rdata = '0;
`endif

    // State register.
    always_ff @(posedge clk_from_cpu or posedge rst_from_cpu) begin
        if (rst_from_cpu) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and CPU/slave strobes.
    always_comb begin
        w_state_nxt  = r_state;
        ack_to_cpu   = 1'b0;
        err_to_cpu   = 1'b0;
        rdata_to_cpu = '0;
        sel_to_slv   = '0;
        we_to_slv    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_from_cpu) begin
                    if (w_int_hit) begin
                        w_state_nxt = S_ACCESS;
                    end else if (w_miss) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                sel_to_slv = r_sel;
                we_to_slv  = r_we & (|r_sel);
                if (w_rdy) begin
                    w_state_nxt = S_DONE;
                end else if (w_cnt_nxt >= 8'(TIMEOUT)) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                ack_to_cpu   = 1'b1;
                rdata_to_cpu = r_rdata;
                w_state_nxt  = S_IDLE;
            end
            S_ERR: begin
                err_to_cpu   = 1'b1;
                rdata_to_cpu = ERR_RDATA;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the request on accept; count waits and latch read data.
    always_ff @(posedge clk_from_cpu or posedge rst_from_cpu) begin
        if (rst_from_cpu) begin
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_sel   <= w_int_hit ? '0 : w_hit;
            r_we    <= we_from_cpu;
            r_wstrb <= wstrb_from_cpu;
            r_addr  <= addr_from_cpu;
            r_wdata <= wdata_from_cpu;
            r_rdata <= w_int_rdata;
            r_cnt   <= '0;
        end else if (r_state == S_ACCESS) begin
            r_cnt <= w_cnt_nxt;
            if (w_rdy && (|r_sel)) begin
                r_rdata <= r_we ? '0 : w_slv_rdata;
            end
        end
    end

endmodule

// File: tb/tb_periph_bridge_n.sv
// tb_periph_bridge_n: scoreboard bench for periph_bridge_n using the
// default SoC windows; error log cases follow BRIDGE_ERRLOG_EN.
module tb_periph_bridge_n;
    import bridge_pkg::*;

    localparam int N = 5;
    localparam logic [31:0] LOG_A = 32'hFFFF_F100;

    typedef struct {
        bit          err;
        logic [31:0] rd;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req = 1'b0;
    logic           we = 1'b0;
    logic [3:0]     wstrb = '0;
    logic [31:0]    addr = '0;
    logic [31:0]    wdata = '0;
    logic [31:0]    rdata;
    logic           ack;
    logic           err;
    logic [N-1:0]   sel;
    logic           we_s;
    logic [3:0]     wstrb_s;
    logic [31:0]    addr_s;
    logic [31:0]    wdata_s;
    logic [N*32-1:0] slv_rdata;
    logic [N-1:0]   ready;

    logic [N-1:0]   rdy_tie = '0;
    logic [N-1:0]   rdy_en = '0;
    int             rdy_wait [N];
    int             sel_cyc = 0;

    exp_t exp_q [$];
    int checks = 0;
    int errors = 0;

    periph_bridge_n #(
        .N_SLV    (N),
        .AW       (32),
        .DW       (32),
        .SLV_BASE (SOC_BASE),
        .SLV_MASK (SOC_MASK),
        .TIMEOUT  (15)
    ) dut (
        .clk_from_cpu   (clk),
        .rst_from_cpu   (rst),
        .req_from_cpu   (req),
        .we_from_cpu    (we),
        .wstrb_from_cpu (wstrb),
        .addr_from_cpu  (addr),
        .wdata_from_cpu (wdata),
        .rdata_to_cpu   (rdata),
        .ack_to_cpu     (ack),
        .err_to_cpu     (err),
        .sel_to_slv     (sel),
        .we_to_slv      (we_s),
        .wstrb_to_slv   (wstrb_s),
        .addr_to_slv    (addr_s),
        .wdata_to_slv   (wdata_s),
        .rdata_from_slv (slv_rdata),
        .ready_from_slv (ready)
    );

    always #5 clk = ~clk;

    assign slv_rdata = {32'hA5A5_0004, 32'hC0DE_0003, 32'h1234_5678,
                        32'h0BAD_0001, 32'h0D0A_0000};

    always_comb begin
        ready = '0;
        for (int i = 0; i < N; i++) begin
            ready[i] = rdy_tie[i] |
                       (rdy_en[i] & sel[i] & (sel_cyc >= rdy_wait[i]));
        end
    end

    always @(posedge clk) begin
        sel_cyc <= (sel != '0) ? sel_cyc + 1 : 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (ack || err) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected ack=%0b err=%0b rdata=%h",
                         ack, err, rdata);
            end else begin
                e = exp_q.pop_front();
                if ({ack, err} !== {~e.err, e.err} || rdata !== e.rd) begin
                    errors++;
                    $display("FAIL sb_resp got ack=%0b err=%0b rdata=%h want err=%0b rdata=%h",
                             ack, err, rdata, e.err, e.rd);
                end
            end
        end
    end

    task automatic do_access(
        input  logic         w,
        input  logic [31:0]  a,
        input  logic [31:0]  d,
        input  bit           xerr,
        input  logic [31:0]  xrd,
        output int           cyc,
        output int           nsel,
        output logic [N-1:0] sel1,
        output logic         we1,
        output logic [31:0]  a1,
        output logic [31:0]  d1,
        output bit           stable
    );
        bit done;
        @(negedge clk);
        exp_q.push_back('{xerr, xrd});
        req = 1'b1;
        we = w;
        addr = a;
        wdata = d;
        wstrb = w ? 4'hF : 4'h0;
        cyc = 0;
        nsel = 0;
        sel1 = '0;
        we1 = 1'b0;
        a1 = '0;
        d1 = '0;
        stable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (sel != '0) begin
                if (nsel == 0) begin
                    sel1 = sel;
                    we1 = we_s;
                    a1 = addr_s;
                    d1 = wdata_s;
                end else if (sel !== sel1 || we_s !== we1 ||
                             addr_s !== a1 || wdata_s !== d1) begin
                    stable = 1'b0;
                end
                nsel++;
            end
            if (ack || err) done = 1'b1;
        end
        if (!done) cyc = -1;
        req = 1'b0;
        we = 1'b0;
        addr = '0;
        wdata = '0;
        wstrb = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({sel, ack, err, we_s, rdata, addr_s} !== '0) begin
            errors++;
            $display("FAIL reset_in got sel=%b ack=%b err=%b rdata=%h want 0",
                     sel, ack, err, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({sel, ack, err, we_s, rdata} !== '0) begin
            errors++;
            $display("FAIL reset_out got sel=%b ack=%b err=%b rdata=%h want 0",
                     sel, ack, err, rdata);
        end
    endtask

    task automatic test_load_zero_wait();
        int c, n; logic [N-1:0] s1; logic w1; logic [31:0] a1, d1; bit st;
        rdy_tie = 5'b00100;
        do_access(1'b0, 32'h8000_0104, '0, 1'b0, 32'h1234_5678,
                  c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 2 || n !== 1 || s1 !== 5'b00100) begin
            errors++;
            $display("FAIL load2 got cyc=%0d nsel=%0d sel=%b want 2 1 00100",
                     c, n, s1);
        end
        rdy_tie = 5'b00001;
        do_access(1'b0, 32'h0000_1000, '0, 1'b0, 32'h0D0A_0000,
                  c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 2 || s1 !== 5'b00001 || a1 !== 32'h0000_1000) begin
            errors++;
            $display("FAIL load0 got cyc=%0d sel=%b addr=%h want 2 00001 00001000",
                     c, s1, a1);
        end
        rdy_tie = '0;
    endtask

    task automatic test_store_wait();
        int c, n; logic [N-1:0] s1; logic w1; logic [31:0] a1, d1; bit st;
        rdy_en = 5'b01000;
        rdy_wait[3] = 3;
        rdy_tie = 5'b10000;
        do_access(1'b1, 32'h8000_0208, 32'hCAFE_F00D, 1'b0, '0,
                  c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 5 || n !== 4) begin
            errors++;
            $display("FAIL store3_lat got cyc=%0d nsel=%0d want 5 4", c, n);
        end
        checks++;
        if (!st || s1 !== 5'b01000 || w1 !== 1'b1 || d1 !== 32'hCAFE_F00D ||
            a1 !== 32'h8000_0208) begin
            errors++;
            $display("FAIL store3_bus got st=%0b sel=%b we=%b d=%h a=%h want 1 01000 1 cafef00d 80000208",
                     st, s1, w1, d1, a1);
        end
        rdy_tie = '0;
    endtask

    task automatic test_unmapped();
        int c, n; logic [N-1:0] s1; logic w1; logic [31:0] a1, d1; bit st;
        do_access(1'b0, 32'h9000_0000, '0, 1'b1, 32'hDEAD_BFEE,
                  c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 1 || n !== 0) begin
            errors++;
            $display("FAIL unmapped got cyc=%0d nsel=%0d want 1 0", c, n);
        end
    endtask

    task automatic test_timeout();
        int c, n; logic [N-1:0] s1; logic w1; logic [31:0] a1, d1; bit st;
        rdy_en = '0;
        do_access(1'b0, 32'h8000_0010, '0, 1'b1, 32'hDEAD_BFEE,
                  c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 16 || n !== 15 || s1 !== 5'b00010) begin
            errors++;
            $display("FAIL timeout got cyc=%0d nsel=%0d sel=%b want 16 15 00010",
                     c, n, s1);
        end
        rdy_tie = 5'b00100;
        do_access(1'b0, 32'h8000_0100, '0, 1'b0, 32'h1234_5678,
                  c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 2) begin
            errors++;
            $display("FAIL after_timeout got cyc=%0d want 2", c);
        end
        rdy_tie = '0;
        rdy_en = 5'b01000;
        rdy_wait[3] = 14;
        do_access(1'b0, 32'h8000_0200, '0, 1'b0, 32'hC0DE_0003,
                  c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 16 || n !== 15) begin
            errors++;
            $display("FAIL ready_at_limit got cyc=%0d nsel=%0d want 16 15", c, n);
        end
        rdy_en = '0;
    endtask

    task automatic test_req_drop();
        int c;
        rdy_en = 5'b01000;
        rdy_wait[3] = 3;
        @(negedge clk);
        exp_q.push_back('{1'b0, 32'hC0DE_0003});
        req = 1'b1;
        addr = 32'h8000_0200;
        c = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            req = 1'b0;
            addr = 32'h9999_0000;
            if (ack || err) begin
                c = i;
                break;
            end
        end
        addr = '0;
        checks++;
        if (c !== 5) begin
            errors++;
            $display("FAIL req_drop got cyc=%0d want 5", c);
        end
        rdy_en = '0;
    endtask

    task automatic test_back_to_back();
        logic [8:0] mask;
        rdy_tie = 5'b00100;
        mask = '0;
        @(negedge clk);
        repeat (3) exp_q.push_back('{1'b0, 32'h1234_5678});
        req = 1'b1;
        addr = 32'h8000_0104;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ack) mask[i] = 1'b1;
        end
        req = 1'b0;
        addr = '0;
        checks++;
        if (mask !== 9'b1_0010_0100) begin
            errors++;
            $display("FAIL back_to_back got ack_cycles=%b want 100100100", mask);
        end
        rdy_tie = '0;
    endtask

    task automatic test_reset_mid();
        int c, n; logic [N-1:0] s1; logic w1; logic [31:0] a1, d1; bit st;
        @(negedge clk);
        req = 1'b1;
        addr = 32'h8000_0020;
        repeat (3) @(negedge clk);
        checks++;
        if (sel !== 5'b00010) begin
            errors++;
            $display("FAIL mid_sel got sel=%b want 00010", sel);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sel, ack, err} !== '0) begin
            errors++;
            $display("FAIL mid_reset got sel=%b ack=%b err=%b want 0",
                     sel, ack, err);
        end
        req = 1'b0;
        addr = '0;
        @(negedge clk);
        rst = 1'b0;
        rdy_tie = 5'b00100;
        do_access(1'b0, 32'h8000_0104, '0, 1'b0, 32'h1234_5678,
                  c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 2) begin
            errors++;
            $display("FAIL post_reset got cyc=%0d want 2", c);
        end
        rdy_tie = '0;
    endtask

    task automatic test_errlog();
        int c, n; logic [N-1:0] s1; logic w1; logic [31:0] a1, d1; bit st;
`ifdef BRIDGE_ERRLOG_EN
        do_access(1'b1, LOG_A, '0, 1'b0, '0, c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 2 || n !== 0) begin
            errors++;
            $display("FAIL log_clr got cyc=%0d nsel=%0d want 2 0", c, n);
        end
        do_access(1'b0, 32'h9000_0000, '0, 1'b1, 32'hDEAD_BFEE,
                  c, n, s1, w1, a1, d1, st);
        do_access(1'b0, 32'hA000_0010, '0, 1'b1, 32'hDEAD_BFEE,
                  c, n, s1, w1, a1, d1, st);
        do_access(1'b0, LOG_A, '0, 1'b0, 32'h0200_0000,
                  c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 2) begin
            errors++;
            $display("FAIL log_cnt got cyc=%0d want 2", c);
        end
        do_access(1'b0, LOG_A + 32'd4, '0, 1'b0, 32'hA000_0010,
                  c, n, s1, w1, a1, d1, st);
        do_access(1'b1, LOG_A, '0, 1'b0, '0, c, n, s1, w1, a1, d1, st);
        do_access(1'b0, LOG_A, '0, 1'b0, '0, c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 2) begin
            errors++;
            $display("FAIL log_cleared got cyc=%0d want 2", c);
        end
`else
        do_access(1'b0, LOG_A, '0, 1'b1, 32'hDEAD_BFEE,
                  c, n, s1, w1, a1, d1, st);
        checks++;
        if (c !== 1 || n !== 0) begin
            errors++;
            $display("FAIL log_addr_unmapped got cyc=%0d nsel=%0d want 1 0",
                     c, n);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < N; i++) rdy_wait[i] = 0;
        test_reset();
        test_load_zero_wait();
        test_store_wait();
        test_unmapped();
        test_timeout();
        test_req_drop();
        test_back_to_back();
        test_reset_mid();
        test_errlog();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_bridge_n.md
Name: periph_bridge_n

Overview:
Parametrised, registered successor to the SoC CPU/peripheral bridge. It accepts single CPU load/store requests and decodes them against N programmable base/mask windows. It drives one selected peripheral slot with a ready/wait-state handshake and returns data, ack or bus error to the CPU. Slow peripherals such as the timer and 7-seg stall the CPU instead of being assumed single-cycle, and unmapped or hung accesses terminate with an error.

Parameters:
- N_SLV, 5, number of peripheral slots (1..8); slot 0 is DRAM by convention.
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- SLV_BASE, {N_SLV{AW'h0}}, packed base address per slot, slot i at bits [i*AW +: AW].
- SLV_MASK, {N_SLV{AW'h0}}, packed compare mask per slot; a 1 bit is compared.
- TIMEOUT, 15, maximum wait cycles for slave ready before bus error (1..255).
- ERR_RDATA, 32'hDEADBFEE, rdata returned on error.

Ports:
- clk_from_cpu  in  1  clock.
- rst_from_cpu  in  1  reset; asynchronous, active-high.
- req_from_cpu  in  1  access request; held until ack_to_cpu or err_to_cpu.
- we_from_cpu  in  1  1 = store, 0 = load.
- wstrb_from_cpu  in  DW/8  byte write strobes.
- addr_from_cpu  in  AW  byte address.
- wdata_from_cpu  in  DW  store data.
- rdata_to_cpu  out  DW  load data, valid with ack/err.
- ack_to_cpu  out  1  one-cycle completion pulse.
- err_to_cpu  out  1  one-cycle bus-error pulse.
- sel_to_slv  out  N_SLV  one-hot slot select.
- we_to_slv  out  1  write enable, qualified by sel.
- wstrb_to_slv  out  DW/8  registered strobes.
- addr_to_slv  out  AW  registered address.
- wdata_to_slv  out  DW  registered store data.
- rdata_from_slv  in  N_SLV*DW  packed read data per slot.
- ready_from_slv  in  N_SLV  per-slot ready.

Behaviour:
- Reset (async): state IDLE; all outputs 0 except rdata_to_cpu = 0; timeout counter = 0. Reset mid-access drops sel immediately and leaves no pending ack.
- Decode: slot i hits when (addr & MASK_i) == (BASE_i & MASK_i). The lowest index wins on overlap. No hit means unmapped.
- FSM IDLE: on req_from_cpu, register addr, wdata, we and wstrb.
  - On a hit: set the one-hot sel and go to ACCESS.
  - On no hit: go to ERR.
- FSM ACCESS: sel, we, addr, wdata and wstrb are held stable. The counter increments each cycle.
  - When ready of the selected slot is high: capture that slot's rdata (loads; stores capture 0) and go to DONE.
  - When the counter reaches TIMEOUT with no ready: go to ERR.
  - Ready from unselected slots is ignored.
- FSM DONE: ack_to_cpu = 1 for one cycle with rdata valid; sel = 0; then IDLE.
- FSM ERR: err_to_cpu = 1 for one cycle; rdata_to_cpu = ERR_RDATA; sel = 0; then IDLE.
- Latency: req accepted at cycle 0, sel high in cycle 1. Ready in cycle k (k ≥ 1) gives ack in cycle k+1, so a zero-wait slave is 2 cycles. An unmapped address gives err in cycle 1.
- Back-to-back: req still high in the DONE/ERR cycle is not accepted; the next accept is in IDLE one cycle later. Minimum spacing is 3 cycles.
- Inputs from the CPU are ignored outside IDLE. A req deassertion mid-access does not abort the access.
- Ready high in the same cycle the counter hits TIMEOUT: ready wins, giving DONE.
- The counter is 8 bits and clears on every accept.

Optional Feature:
- Macro BRIDGE_ERRLOG_EN, with parameter ERRLOG_ADDR = 32'hFFFF_F100.
- When defined: on every ERR, err_addr_q captures the faulting address and err_cnt_q, 8-bit saturating at 255, increments.
  - A load at ERRLOG_ADDR returns {err_cnt_q, 24'b0}.
  - A load at ERRLOG_ADDR+4 returns err_addr_q.
  - Both take priority over slot decode and complete via DONE in 2 cycles.
  - A store to ERRLOG_ADDR clears both registers.
- When undefined: no registers exist and these addresses decode normally.

Decomposition:
- Package bridge_pkg holds the state encoding (IDLE, ACCESS, DONE, ERR), ERR_RDATA, and default SoC windows: DRAM, LED, SW, DIG and TIMER base/mask constants.
- Sub-module bridge_addr_decoder is purely combinational: addr in, one-hot hit vector and a miss flag out, with lowest-index priority.

Test Plan:
- Load from slot 2 with ready tied high, rdata slot2 = 32'h1234_5678: ack in cycle 2 with rdata_to_cpu = 32'h1234_5678; sel = 5'b00100 in cycle 1 only.
- Store to slot 3 with ready delayed 4 cycles: sel, we and wdata stable for 4 cycles; ack in cycle 5; no err.
- Load from an unmapped address: err in cycle 1, rdata_to_cpu = 32'hDEADBFEE, sel never asserted.
- Slot 1 never ready with TIMEOUT = 15: err pulse after 15 ACCESS cycles; the next req is accepted normally.
- Reset asserted during ACCESS: sel, ack and err are 0 asynchronously; after release a fresh load completes in 2 cycles.
- With BRIDGE_ERRLOG_EN, two unmapped accesses then a load at ERRLOG_ADDR: returns 32'h0200_0000. A store to ERRLOG_ADDR then clears it, so a following load returns 0.
